nibble_fetch_decode: RTL and testbench
======================================

// Module: nibble_fetch_decode
// PURPOSE
//  Fetch/decode controller directly upstream of the 4-bit datapath (input bus driver, ALU, accumulator, output bus driver).
//  Holds the program counter, fetches 8-bit words from a combinational program ROM and decodes each word.
//  Drives the datapath controls: input-bus enable, output-bus enable, accumulator enable, ALU function and immediate operand.
//  Latches the ALU C/Z flags and uses them for conditional jumps.
// PARAMETERS
//  PC_W    12  program counter width; jump target = {operand nibble, second byte}, so PC_W = 12
//  INSTR_W  8  ROM word width; opcode = [7:4], operand = [3:0]
// PORTS
//  CLK        in   1   single clock; all state updates on its rising edge
//  RESET      in   1   synchronous, active-low reset
//  PROG_BYTE  in   8   ROM data at address PC; valid in the same cycle (combinational ROM)
//  C_IN       in   1   ALU carry/borrow output
//  Z_IN       in   1   ALU zero output
//  PC         out  12  ROM address (current program counter)
//  OPRND      out  4   immediate operand; feeds the input bus driver data
//  F          out  3   ALU function code
//  ENB1       out  1   input bus driver enable
//  ENB2       out  1   output bus driver enable
//  ENACU      out  1   accumulator load enable
//  PHASE      out  1   0 = FETCH, 1 = EXEC (also 1 in JMP2)
//  HALTED     out  1   high while in HALT
// BEHAVIOUR
//  Reset: sampled only on a CLK edge with RESET=0. Sets state=FETCH, PC=0, IR=0, CF=0, ZF=0.
//   Applies from any state, including mid-instruction and HALT.
//  Control outputs are decoded from state and IR only.
//   FETCH, HALT and reset: ENB1=ENB2=ENACU=0, F=000, OPRND=IR[3:0].
//  FETCH: IR<=PROG_BYTE, PC<=PC+1 (mod 2^12, so 0xFFF wraps to 0x000), then -> EXEC.
//  EXEC asserts controls per IR[7:4]; accumulator and flags capture at the end-of-EXEC edge, then -> FETCH.
//   0x0 NOP : no enables
//   0x1 LIT : F=010, ENB1=1, ENACU=1 (ACC<=n)
//   0x2 ADDI: F=011, ENB1=1, ENACU=1; CF<=C_IN, ZF<=Z_IN
//   0x3 SUBI: F=001, ENB1=1, ENACU=1; flags updated
//   0x4 CMPI: F=001, ENB1=1, ENACU=0; flags updated
//   0x5 NORI: F=100, ENB1=1, ENACU=1; flags unchanged
//   0x6 OUT : F=000, ENB2=1 (accumulator driven onto output bus)
//   0x7 JC, 0x8 JZ, 0x9 JNC, 0xA JMP: two-byte instructions; EXEC -> JMP2, no datapath enables
//   0xB HALT: -> HALT; PC frozen; leaves HALT only via reset
//   0xC-0xF: treated as NOP
//  Flags are written only by ADDI, SUBI and CMPI; every other opcode holds them.
//  JMP2: PROG_BYTE (the byte at PC) is the low target byte.
//   Taken (JMP always; JC if CF; JZ if ZF; JNC if !CF): PC<={IR[3:0],PROG_BYTE}.
//   Not taken: PC<=PC+1.
//   Then -> FETCH. No enables asserted; PHASE=1.
//  Latency: 2 cycles per single-byte instruction; 3 cycles per jump, taken or not.
//  A jump whose first byte is at 0xFFF reads its second byte from 0x000 (wrap).
//  States: FETCH, EXEC, JMP2, HALT; 2-bit encoding; unused codes -> FETCH.
// TESTING
//  Reset: RESET=0 for 1 edge, from any state -> PC=000, PHASE=0, all enables 0, HALTED=0.
//  ROM {0x15, 0x23, 0x60} -> EXEC cycles show F=010,OPRND=5,ENB1/ENACU=1; then F=011,OPRND=3; then ENB2=1, F=000; PC 0,1,2,3.
//  CMPI with C_IN=1,Z_IN=1, then JZ 0x4,0x21 -> ENACU=0 during CMPI; PC=0x421 after the JMP2 edge.
//  JZ with ZF=0 at PC=0x010 -> PC=0x012 after 3 cycles; JNC with CF=0 -> taken.
//  PC=0xFFF holding NOP -> PC wraps to 0x000; JMP whose first byte is at 0xFFF takes its low byte from 0x000.
//  HALT -> HALTED=1, PC stable for 10 cycles; RESET=0 asserted mid-EXEC of ADDI -> ENACU=0, flags 0, PC=0.

Source files
------------

// File: rtl/nibble_fetch_decode.sv
// nibble_fetch_decode: fetch/decode controller for the 4-bit nibble datapath.
// Latency: 2 cycles per single-byte instruction (FETCH, EXEC); 3 cycles per jump (FETCH, EXEC, JMP2).
// Backpressure: none; the ROM is combinational and the datapath always accepts its controls.
//
// Ports:
//   CLK, RESET       clock and synchronous active-low reset
//   PROG_BYTE        ROM word at address PC (same cycle)
//   C_IN, Z_IN       ALU carry/borrow and zero, latched by ADDI/SUBI/CMPI
//   PC               ROM address
//   OPRND            immediate nibble (IR[3:0]) for the input bus driver
//   F                ALU function code
//   ENB1/ENB2/ENACU  input bus, output bus and accumulator enables
//   PHASE            0 = FETCH or HALT, 1 = EXEC or JMP2
//   HALTED           high while halted
module nibble_fetch_decode #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] PROG_BYTE,
  input  logic               C_IN,
  input  logic               Z_IN,
  output logic [PC_W-1:0]    PC,
  output logic [3:0]         OPRND,
  output logic [2:0]         F,
  output logic               ENB1,
  output logic               ENB2,
  output logic               ENACU,
  output logic               PHASE,
  output logic               HALTED
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_JMP2  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic               cf, cf_nxt;
  logic               zf, zf_nxt;
  logic [3:0]         opcode;
  logic               taken;

  assign opcode = ir[7:4];

  // Condition for the two-byte jumps; only meaningful in JMP2.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      4'h7:    taken = cf;
      4'h8:    taken = zf;
      4'h9:    taken = ~cf;
      4'hA:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      cf    <= 1'b0;
      zf    <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      cf    <= cf_nxt;
      zf    <= zf_nxt;
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    pc_nxt    = pc;
    ir_nxt    = ir;
    cf_nxt    = cf;
    zf_nxt    = zf;
    F         = 3'b000;
    ENB1      = 1'b0;
    ENB2      = 1'b0;
    ENACU     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_nxt    = PROG_BYTE;
        pc_nxt    = pc + PC_ONE;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          4'h1: begin F = 3'b010; ENB1 = 1'b1; ENACU = 1'b1; end
          4'h2: begin
            F = 3'b011; ENB1 = 1'b1; ENACU = 1'b1;
            cf_nxt = C_IN; zf_nxt = Z_IN;
          end
          4'h3: begin
            F = 3'b001; ENB1 = 1'b1; ENACU = 1'b1;
            cf_nxt = C_IN; zf_nxt = Z_IN;
          end
          // Compare: subtract for the flags only, accumulator untouched.
          4'h4: begin
            F = 3'b001; ENB1 = 1'b1;
            cf_nxt = C_IN; zf_nxt = Z_IN;
          end
          4'h5: begin F = 3'b100; ENB1 = 1'b1; ENACU = 1'b1; end
          4'h6: ENB2 = 1'b1;
          4'h7, 4'h8, 4'h9, 4'hA: state_nxt = S_JMP2;
          4'hB: state_nxt = S_HALT;
          default: ;
        endcase
      end
      // PC already points at the low target byte, so PROG_BYTE is that byte.
      S_JMP2: begin
        pc_nxt    = taken ? {ir[3:0], PROG_BYTE} : pc + PC_ONE;
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign PC     = pc;
  assign OPRND  = ir[3:0];
  assign PHASE  = (state == S_EXEC) || (state == S_JMP2);
  assign HALTED = (state == S_HALT);

endmodule

// File: tb/tb_nibble_fetch_decode.sv
module tb_nibble_fetch_decode;

  logic        CLK;
  logic        RESET;
  logic [7:0]  PROG_BYTE;
  logic        C_IN;
  logic        Z_IN;
  logic [11:0] PC;
  logic [3:0]  OPRND;
  logic [2:0]  F;
  logic        ENB1, ENB2, ENACU, PHASE, HALTED;

  logic [7:0]  rom [0:4095];
  logic [23:0] sb [$];
  logic [23:0] obs, exp_v;
  int          checks = 0;
  int          failures = 0;

  nibble_fetch_decode dut (
    .CLK(CLK), .RESET(RESET), .PROG_BYTE(PROG_BYTE), .C_IN(C_IN), .Z_IN(Z_IN),
    .PC(PC), .OPRND(OPRND), .F(F), .ENB1(ENB1), .ENB2(ENB2), .ENACU(ENACU),
    .PHASE(PHASE), .HALTED(HALTED)
  );

  assign PROG_BYTE = rom[PC];
  assign obs = {PC, OPRND, F, ENB1, ENB2, ENACU, PHASE, HALTED};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected output vector: pc, oprnd, f, enb1, enb2, enacu, phase, halted.
  function automatic logic [23:0] mk(input logic [11:0] pc, input logic [3:0] op,
                                     input logic [2:0] f, input logic e1, input logic e2,
                                     input logic ea, input logic ph, input logic h);
    return {pc, op, f, e1, e2, ea, ph, h};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // Reset for one edge; returns on the following falling edge with RESET released.
  task automatic do_reset();
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    clear_rom();
    C_IN = 1'b0; Z_IN = 1'b0;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset got=%h exp=%h", obs, exp_v);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_alu_ops();
    int i;
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h60;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h001, 4'h5, 3'b010, 1, 0, 1, 1, 0));
    sb.push_back(mk(12'h001, 4'h5, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h002, 4'h3, 3'b011, 1, 0, 1, 1, 0));
    sb.push_back(mk(12'h002, 4'h3, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h003, 4'h0, 3'b000, 0, 1, 0, 1, 0));
    sb.push_back(mk(12'h003, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL alu_ops cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      i++;
      @(negedge CLK);
    end
  endtask

  task automatic test_cmp_jz();
    int i;
    clear_rom();
    rom[12'h000] = 8'h40; rom[12'h001] = 8'h84; rom[12'h002] = 8'h21;
    rom[12'h421] = 8'h95; rom[12'h422] = 8'h00;
    C_IN = 1'b1; Z_IN = 1'b1;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h001, 4'h0, 3'b001, 1, 0, 0, 1, 0));
    sb.push_back(mk(12'h001, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h002, 4'h4, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h002, 4'h4, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h421, 4'h4, 3'b000, 0, 0, 0, 0, 0));
    // JNC with CF=1: not taken, falls through past the low byte
    sb.push_back(mk(12'h422, 4'h5, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h422, 4'h5, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h423, 4'h5, 3'b000, 0, 0, 0, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL cmp_jz cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      i++;
      @(negedge CLK);
    end
  endtask

  task automatic test_jz_not_taken_jnc_taken();
    int i;
    clear_rom();
    rom[12'h000] = 8'hA0; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'h8F; rom[12'h011] = 8'h77;
    rom[12'h012] = 8'h93; rom[12'h013] = 8'h45;
    C_IN = 1'b0; Z_IN = 1'b0;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h001, 4'h0, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h001, 4'h0, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h010, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h011, 4'hF, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h011, 4'hF, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h012, 4'hF, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h013, 4'h3, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h013, 4'h3, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h345, 4'h3, 3'b000, 0, 0, 0, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL jz_jnc cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      i++;
      @(negedge CLK);
    end
  endtask

  task automatic test_wrap(input logic [7:0] last_byte);
    int i;
    clear_rom();
    rom[12'h000] = 8'hAF; rom[12'h001] = 8'hFF;
    rom[12'hFFF] = last_byte;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h001, 4'hF, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h001, 4'hF, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'hFFF, 4'hF, 3'b000, 0, 0, 0, 0, 0));
    if (last_byte == 8'h00) begin
      sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 1, 0));
      sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    end else begin
      // JMP 0x7?? whose low byte is rom[0x000] = 0xAF
      sb.push_back(mk(12'h000, 4'h7, 3'b000, 0, 0, 0, 1, 0));
      sb.push_back(mk(12'h000, 4'h7, 3'b000, 0, 0, 0, 1, 0));
      sb.push_back(mk(12'h7AF, 4'h7, 3'b000, 0, 0, 0, 0, 0));
    end
    i = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL wrap_%h cyc=%0d got=%h exp=%h", last_byte, i, obs, exp_v);
      end
      i++;
      @(negedge CLK);
    end
  endtask

  task automatic test_halt();
    int i;
    clear_rom();
    rom[0] = 8'hB0; rom[1] = 8'h15;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h001, 4'h0, 3'b000, 0, 0, 0, 1, 0));
    for (int k = 0; k < 11; k++) sb.push_back(mk(12'h001, 4'h0, 3'b000, 0, 0, 0, 0, 1));
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      RESET = (i == 12) ? 1'b0 : 1'b1;
      i++;
      @(negedge CLK);
    end
    RESET = 1'b1;
  endtask

  task automatic test_reset_mid_exec();
    int i;
    clear_rom();
    rom[0] = 8'h2F; rom[1] = 8'h2F;
    C_IN = 1'b1; Z_IN = 1'b1;
    do_reset();
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h001, 4'hF, 3'b011, 1, 0, 1, 1, 0));
    sb.push_back(mk(12'h001, 4'hF, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h002, 4'hF, 3'b011, 1, 0, 1, 1, 0));
    sb.push_back(mk(12'h000, 4'h0, 3'b000, 0, 0, 0, 0, 0));
    // Flags were set by the first ADDI; reset must clear them, so JC and JZ fall through.
    sb.push_back(mk(12'h001, 4'h5, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h001, 4'h5, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h002, 4'h5, 3'b000, 0, 0, 0, 0, 0));
    sb.push_back(mk(12'h003, 4'h5, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h003, 4'h5, 3'b000, 0, 0, 0, 1, 0));
    sb.push_back(mk(12'h004, 4'h5, 3'b000, 0, 0, 0, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_exec cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 3) RESET = 1'b0;
      if (i == 4) begin
        RESET = 1'b1;
        rom[0] = 8'h75; rom[1] = 8'h55; rom[2] = 8'h85; rom[3] = 8'h55;
        C_IN = 1'b0; Z_IN = 1'b0;
      end
      i++;
      @(negedge CLK);
    end
  endtask

  initial begin
    RESET = 1'b0;
    C_IN  = 1'b0;
    Z_IN  = 1'b0;
    clear_rom();
    test_reset();
    test_alu_ops();
    test_cmp_jz();
    test_jz_not_taken_jnc_taken();
    test_wrap(8'h00);
    test_wrap(8'hA7);
    test_halt();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
